// File: rtl/sdr_rr_arbiter.sv
// sdr_rr_arbiter
//   Round-robin arbiter that shares one toggle-handshake SDRAM read port
//   between NUM_CLIENTS toggle-handshake ROM clients. One downstream read is
//   outstanding at a time. The client granted last gets the lowest priority
//   in the next round, so no client can be starved.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   cli_addr            client i address at [i*ADDR_W +: ADDR_W]
//   cli_req / cli_ack   per-client request / acknowledge toggles
//   cli_data            per-client read data, client i at [i*DATA_W +: DATA_W]
//   sdr_addr, sdr_req   request to the SDRAM controller (toggle)
//   sdr_ack, sdr_data   controller acknowledge toggle and read data
//   grant_idx           client currently or last granted
//   busy                a downstream read is outstanding

// Per-client return slot. It holds the ack toggle and the data word together,
// so the data is already stable on the edge where the client sees ack == req.
module sdr_rr_slot #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              ack,
    output logic [DATA_W-1:0] data
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack  <= 1'b0;
            data <= '0;
        end else if (load) begin
            ack  <= ~ack;
            data <= din;
        end
    end
endmodule

module sdr_rr_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
    input  logic [NUM_CLIENTS-1:0]        cli_req,
    output logic [NUM_CLIENTS-1:0]        cli_ack,
    output logic [NUM_CLIENTS*DATA_W-1:0] cli_data,
    output logic [ADDR_W-1:0]             sdr_addr,
    output logic                          sdr_req,
    input  logic                          sdr_ack,
    input  logic [DATA_W-1:0]             sdr_data,
    output logic [2:0]                    grant_idx,
    output logic                          busy
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t                 state;
    logic [NUM_CLIENTS-1:0] pending;
    logic [7:0]             pend8;
    logic [3:0]             cand;
    logic                   found;
    logic [2:0]             next_idx;
    logic [ADDR_W-1:0]      addr_sel;
    logic                   done;

    assign pending = cli_req ^ cli_ack;

    // Round-robin scan: the candidate is grant_idx+k for k = 1..NUM_CLIENTS.
    // grant_idx < NUM_CLIENTS and k <= NUM_CLIENTS, so a single subtract
    // does the wrap. At k == NUM_CLIENTS the last-granted client is tried,
    // which makes it the lowest priority.
    always_comb begin
        pend8                    = '0;
        pend8[NUM_CLIENTS-1:0]   = pending;
        found                    = 1'b0;
        next_idx                 = grant_idx;
        cand                     = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            cand = {1'b0, grant_idx} + 4'(k);
            if (cand >= 4'(NUM_CLIENTS))
                cand = cand - 4'(NUM_CLIENTS);
            if (!found && pend8[cand[2:0]]) begin
                found    = 1'b1;
                next_idx = cand[2:0];
            end
        end
    end

    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < NUM_CLIENTS; i++)
            if (next_idx == 3'(i))
                addr_sel = cli_addr[i*ADDR_W +: ADDR_W];
    end

    // The downstream read finishes on this edge.
    assign done = (state == WAIT) && (sdr_ack == sdr_req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= 3'(NUM_CLIENTS - 1);
            sdr_addr  <= '0;
            sdr_req   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_idx <= next_idx;
                        sdr_addr  <= addr_sel;
                        sdr_req   <= ~sdr_req;
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // Completion always returns to IDLE for at least one
                    // cycle, so pending is never evaluated on a completion edge.
                    if (sdr_ack == sdr_req) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_slot
        sdr_rr_slot #(.DATA_W(DATA_W)) u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (done && (grant_idx == 3'(i))),
            .din   (sdr_data),
            .ack   (cli_ack[i]),
            .data  (cli_data[i*DATA_W +: DATA_W])
        );
    end
endmodule
